// File: rtl/timer_pkg.sv
// Shared types and helpers for the BCD stopwatch/countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } timer_state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Clamp an arbitrary nibble into the legal BCD range.
  function automatic logic [3:0] bcd_sat(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the timer count; steps only when the lower digits ripple into it.
module bcd_digit
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step,
  input  logic       up,
  input  logic       cin,
  input  logic       set,
  input  logic [3:0] set_val,
  input  logic       zero,
  output logic [3:0] q,
  output logic       cout
);

  // Carry (up) or borrow (down) passes on when this digit is about to roll over.
  assign cout = cin & (up ? (q == BCD_MAX) : (q == 4'd0));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 4'd0;
    end else if (zero) begin
      q <= 4'd0;
    end else if (set) begin
      q <= set_val;
    end else if (step && cin) begin
      if (up) q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
      else    q <= (q == 4'd0) ? BCD_MAX : q - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_timer.sv
// BCD stopwatch/countdown timer: run-gated prescaler, FSM, BCD digit chain,
// terminal-count pulse and lap-hold display register.
module bcd_timer
  import timer_pkg::*;
#(
  parameter int DIV    = 100_000,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  up,
  input  logic                  wrap,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  lap,
  output logic [4*DIGITS-1:0]   count,
  output logic [4*DIGITS-1:0]   display,
  output logic                  tick,
  output logic                  tc,
  output logic [1:0]            state
);

  localparam int              PW       = $clog2(DIV);
  localparam logic [PW-1:0]   PRE_LAST = PW'(DIV - 1);

  timer_state_t  state_q;
  logic [PW-1:0] pre;
  logic          hold;
  logic [DIGITS:0] carry;
  logic          at_term;
  logic          lands_term;
  logic          step_en;
  logic          expire;

  assign state = state_q;
  assign tick  = (state_q == RUN) && (pre == PRE_LAST);

  assign carry[0] = 1'b1;
  assign at_term  = carry[DIGITS];

  // A stopped timer sitting on its terminal value does not step past it.
  assign step_en = tick & ~clear & ~load & ~(at_term & ~wrap);
  assign expire  = tick & ~clear & ~load & ~wrap & (at_term | lands_term);

  // NOTE: combinational blocks assign a default first so no latch is inferred.
  always_comb begin
    lands_term = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (i == 0) lands_term &= (count[3:0] == (up ? 4'd8 : 4'd1));
      else        lands_term &= (count[4*i +: 4] == (up ? BCD_MAX : 4'd0));
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [3:0] sat_val;
    assign sat_val = bcd_sat(load_val[4*i +: 4]);

    bcd_digit u_digit (
      .clk     (clk),
      .rst_n   (rst_n),
      .step    (step_en),
      .up      (up),
      .cin     (carry[i]),
      .set     (load),
      .set_val (sat_val),
      .zero    (clear),
      .q       (count[4*i +: 4]),
      .cout    (carry[i+1])
    );
  end

  // NOTE: every control register resets asynchronously so reset acts mid-run without a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    if (en) state_q <= RUN;
        RUN:     if (expire) state_q <= EXPIRED;
                 else if (!en) state_q <= IDLE;
        EXPIRED: if (clear || load) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
    end else if (state_q != RUN || clear || load || pre == PRE_LAST) begin
      pre <= '0;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tc <= 1'b0;
    else        tc <= step_en & lands_term;
  end

  // While not holding, display trails count by one edge; the 0->1 edge of hold
  // therefore captures the count present at the lap pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold    <= 1'b0;
      display <= '0;
    end else begin
      if (!hold) display <= count;
      if (clear)    hold <= 1'b0;
      else if (lap) hold <= ~hold;
    end
  end

endmodule

// File: tb/tb_bcd_timer.sv
// Self-checking bench for bcd_timer (DIV=4, DIGITS=4): directed scenarios plus
// randomized traffic against an integer-arithmetic reference model.
module tb_bcd_timer;

  localparam int DIV    = 4;
  localparam int DIGITS = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        en    = 1'b0;
  logic        up    = 1'b1;
  logic        wrap  = 1'b0;
  logic        clear = 1'b0;
  logic        load  = 1'b0;
  logic [15:0] load_val = 16'h0000;
  logic        lap   = 1'b0;
  logic [15:0] count;
  logic [15:0] display;
  logic        tick;
  logic        tc;
  logic [1:0]  state;

  int total = 0;
  int bad   = 0;

  bcd_timer #(.DIV(DIV), .DIGITS(DIGITS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up       (up),
    .wrap     (wrap),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
    .lap      (lap),
    .count    (count),
    .display  (display),
    .tick     (tick),
    .tc       (tc),
    .state    (state)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (decimal integers) ----------------
  function automatic int bcd_to_int(input logic [15:0] v);
    int r = 0;
    for (int i = 3; i >= 0; i--) begin
      int d;
      d = int'((v >> (4 * i)) & 16'h000F);
      if (d > 9) d = 9;
      r = r * 10 + d;
    end
    return r;
  endfunction

  function automatic logic [15:0] int_to_bcd(input int n);
    logic [15:0] r;
    int k;
    k = n;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(k % 10);
      k = k / 10;
    end
    return r;
  endfunction

  int m_cnt = 0, m_disp = 0, m_pre = 0, m_state = 0;
  bit m_hold = 0, m_tc = 0;
  int n_cnt, n_state, n_pre, n_disp, term;
  bit m_tk, n_tc, n_hold, n_exp;

  always_comb begin
    m_tk  = (m_state == 1) && (m_pre == DIV - 1);
    term  = up ? 9999 : 0;
    n_cnt = m_cnt;
    n_tc  = 1'b0;
    n_exp = 1'b0;
    if (clear)      n_cnt = 0;
    else if (load)  n_cnt = bcd_to_int(load_val);
    else if (m_tk) begin
      if (m_cnt == term && !wrap) n_exp = 1'b1;
      else begin
        n_cnt = up ? (m_cnt + 1) % 10000 : (m_cnt + 9999) % 10000;
        n_tc  = (n_cnt == term);
        n_exp = n_tc && !wrap;
      end
    end
    n_state = m_state;
    case (m_state)
      0: if (en) n_state = 1;
      1: if (n_exp) n_state = 2; else if (!en) n_state = 0;
      2: if (clear || load) n_state = 0;
      default: n_state = 0;
    endcase
    n_pre  = (m_state != 1 || clear || load || m_pre == DIV - 1) ? 0 : m_pre + 1;
    n_disp = m_hold ? m_disp : m_cnt;
    n_hold = clear ? 1'b0 : (lap ? !m_hold : m_hold);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0; m_disp <= 0; m_pre <= 0; m_state <= 0; m_hold <= 0; m_tc <= 0;
    end else begin
      m_cnt <= n_cnt; m_disp <= n_disp; m_pre <= n_pre;
      m_state <= n_state; m_hold <= n_hold; m_tc <= n_tc;
    end
  end

  // ---------------- bounded waits ----------------
  task automatic wait_tick();
    int n = 0;
    while (tick !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (tick !== 1'b1) begin
      bad++;
      $display("FAIL wait_tick: tick=%b after %0d cycles, required 1", tick, n);
    end
  endtask

  task automatic wait_count(input logic [15:0] target);
    int n = 0;
    while (count !== target && n < 400) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (count !== target) begin
      bad++;
      $display("FAIL wait_count: count=%h, required %h", count, target);
    end
  endtask

  task automatic pulse_load(input logic [15:0] v);
    load_val = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic pulse_lap();
    lap = 1'b1;
    @(negedge clk);
    lap = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (count !== 16'h0 || display !== 16'h0 || tick !== 1'b0 || tc !== 1'b0 || state !== 2'd0) begin
      bad++;
      $display("FAIL reset: count=%h display=%h tick=%b tc=%b state=%0d, required 0/0/0/0/0",
               count, display, tick, tc, state);
    end
  endtask

  task automatic test_up_count();
    up = 1'b1; wrap = 1'b0; en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        total++;
        if (tick !== 1'b0 || count !== int_to_bcd(k)) begin
          bad++;
          $display("FAIL up_gap: step %0d cyc %0d tick=%b count=%h, required 0 %h",
                   k, c, tick, count, int_to_bcd(k));
        end
      end
      @(negedge clk);
      total++;
      if (tick !== 1'b1 || count !== int_to_bcd(k)) begin
        bad++;
        $display("FAIL up_tick: step %0d tick=%b count=%h, required 1 %h", k, tick, count, int_to_bcd(k));
      end
    end
    @(negedge clk);
    total++;
    if (count !== 16'h0010 || state !== 2'd1) begin
      bad++;
      $display("FAIL up_final: count=%h state=%0d, required 0010 1", count, state);
    end
    en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_down_expire();
    up = 1'b0; wrap = 1'b0;
    pulse_load(16'h0003);
    total++;
    if (count !== 16'h0003 || tc !== 1'b0) begin
      bad++;
      $display("FAIL down_load: count=%h tc=%b, required 0003 0", count, tc);
    end
    en = 1'b1;
    for (int k = 2; k >= 0; k--) begin
      wait_tick();
      @(negedge clk);
      total++;
      if (count !== int_to_bcd(k) || tc !== (k == 0) || state !== ((k == 0) ? 2'd2 : 2'd1)) begin
        bad++;
        $display("FAIL down_step: count=%h tc=%b state=%0d, required %h %b %0d",
                 count, tc, state, int_to_bcd(k), (k == 0), (k == 0) ? 2 : 1);
      end
    end
    @(negedge clk);
    total++;
    if (tc !== 1'b0) begin
      bad++;
      $display("FAIL down_tc_width: tc=%b, required 0", tc);
    end
    repeat (12) @(negedge clk);
    total++;
    if (count !== 16'h0000 || state !== 2'd2 || tick !== 1'b0) begin
      bad++;
      $display("FAIL expired_hold: count=%h state=%0d tick=%b, required 0000 2 0", count, state, tick);
    end
    en = 1'b0;
    pulse_load(16'h0005);
    total++;
    if (state !== 2'd0 || count !== 16'h0005) begin
      bad++;
      $display("FAIL expired_exit: state=%0d count=%h, required 0 0005", state, count);
    end
  endtask

  task automatic test_wrap();
    up = 1'b1; wrap = 1'b1;
    pulse_load(16'h9998);
    en = 1'b1;
    wait_tick();
    @(negedge clk);
    total++;
    if (count !== 16'h9999 || tc !== 1'b1 || state !== 2'd1) begin
      bad++;
      $display("FAIL wrap_9999: count=%h tc=%b state=%0d, required 9999 1 1", count, tc, state);
    end
    @(negedge clk);
    wait_tick();
    @(negedge clk);
    total++;
    if (count !== 16'h0000 || tc !== 1'b0 || state !== 2'd1) begin
      bad++;
      $display("FAIL wrap_0000: count=%h tc=%b state=%0d, required 0000 0 1", count, tc, state);
    end
    en = 1'b0; wrap = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_priority();
    up = 1'b1;
    pulse_load(16'hA5F3);
    total++;
    if (count !== 16'h9593) begin
      bad++;
      $display("FAIL sanitise: count=%h, required 9593", count);
    end
    load_val = 16'h1234; load = 1'b1; clear = 1'b1;
    @(negedge clk);
    load = 1'b0; clear = 1'b0;
    total++;
    if (count !== 16'h0000) begin
      bad++;
      $display("FAIL clear_over_load: count=%h, required 0000", count);
    end
    pulse_load(16'h0100);
    en = 1'b1;
    wait_tick();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    total++;
    if (count !== 16'h0000 || tick !== 1'b0) begin
      bad++;
      $display("FAIL clear_over_tick: count=%h tick=%b, required 0000 0", count, tick);
    end
    wait_tick();
    @(negedge clk);
    total++;
    if (count !== 16'h0001) begin
      bad++;
      $display("FAIL after_clear_step: count=%h, required 0001", count);
    end
    en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_lap();
    logic [15:0] prev;
    up = 1'b1;
    pulse_clear();
    en = 1'b1;
    wait_count(16'h0012);
    pulse_lap();
    total++;
    if (display !== 16'h0012) begin
      bad++;
      $display("FAIL lap_capture: display=%h, required 0012", display);
    end
    wait_count(16'h0015);
    total++;
    if (display !== 16'h0012) begin
      bad++;
      $display("FAIL lap_hold: display=%h count=%h, required 0012", display, count);
    end
    pulse_lap();
    prev = count;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if (display !== prev) begin
        bad++;
        $display("FAIL lap_follow: cyc %0d display=%h, required %h", c, display, prev);
      end
      prev = count;
    end
    en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    up = 1'b1;
    pulse_clear();
    en = 1'b1;
    wait_count(16'h0047);
    pulse_lap();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (count !== 16'h0 || display !== 16'h0 || tick !== 1'b0 || tc !== 1'b0 || state !== 2'd0) begin
      bad++;
      $display("FAIL reset_mid: count=%h display=%h tick=%b tc=%b state=%0d, required all 0",
               count, display, tick, tc, state);
    end
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    total++;
    if (count !== 16'h0 || state !== 2'd0 || display !== 16'h0) begin
      bad++;
      $display("FAIL reset_idle: count=%h state=%0d display=%h, required 0000 0 0000", count, state, display);
    end
    en = 1'b1;
    wait_tick();
    @(negedge clk);
    total++;
    if (count !== 16'h0001) begin
      bad++;
      $display("FAIL reset_restart: count=%h, required 0001", count);
    end
    en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    logic [15:0] picks [5];
    picks[0] = 16'h9998; picks[1] = 16'h0001; picks[2] = 16'h9999;
    picks[3] = 16'h0000; picks[4] = 16'h0000;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      total++;
      if (count !== int_to_bcd(m_cnt) || display !== int_to_bcd(m_disp) || tick !== m_tk ||
          tc !== m_tc || state !== 2'(m_state)) begin
        bad++;
        $display("FAIL random: cyc %0d count=%h display=%h tick=%b tc=%b state=%0d, required %h %h %b %b %0d",
                 c, count, display, tick, tc, state, int_to_bcd(m_cnt), int_to_bcd(m_disp),
                 m_tk, m_tc, m_state);
      end
      en    = ($urandom_range(0, 15) != 0);
      clear = ($urandom_range(0, 59) == 0);
      load  = ($urandom_range(0, 39) == 0);
      lap   = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 49) == 0) up = ~up;
      if ($urandom_range(0, 99) == 0) wrap = ~wrap;
      picks[4] = 16'($urandom);
      load_val = picks[$urandom_range(0, 4)];
    end
    clear = 1'b0; load = 1'b0; lap = 1'b0; en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_down_expire();
    test_wrap();
    test_priority();
    test_lap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_timer.md
# bcd_timer

Parametrised BCD stopwatch/countdown timer that supersedes the fixed binary up-counter and free-running refresh divider pair on the Nexys board top level. It adds a run-gated prescaler, a multi-digit BCD count with up/down direction, preset load, terminal-count handling (stop or wrap), and a lap-hold display register. Its outputs feed `sseg4_TDM` directly in decimal mode.

## Interface

Parameters:
- `DIV`, 100_000: prescaler period in `clk` cycles per count step. Minimum 2.
- `DIGITS`, 4: number of BCD digits. Count width is 4*DIGITS.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: run request (level).
- `up` in 1: direction; 1 counts up, 0 counts down. Sampled at each step.
- `wrap` in 1: 1 wraps at the terminal value, 0 stops there (EXPIRED).
- `clear` in 1: synchronous pulse; sets count to 0.
- `load` in 1: synchronous pulse; sets count to `load_val`.
- `load_val` in 4*DIGITS: preset value as packed BCD, with digit 0 in the LSBs.
- `lap` in 1: pulse; toggles the display hold.
- `count` out 4*DIGITS: live BCD count.
- `display` out 4*DIGITS: value for the 7-seg path; either the live count or the held lap value.
- `tick` out 1: one-cycle pulse on every count step.
- `tc` out 1: one-cycle terminal-count pulse.
- `state` out 2: current FSM state, for debug and LEDs.

## Operation

- **FSM states:** IDLE=0, RUN=1, EXPIRED=2.
  - IDLE→RUN when `en`=1.
  - RUN→IDLE when `en`=0.
  - RUN→EXPIRED when a step lands on the terminal value and `wrap`=0.
  - EXPIRED→IDLE on `clear` or `load`. `en` is ignored while EXPIRED.
- **Prescaler:**
  - Counts 0..DIV-1, and only while in RUN.
  - Reset to 0 in IDLE and EXPIRED, and on `clear` or `load`.
  - `tick` is asserted while prescaler = DIV-1 in RUN. The count steps on that edge and the prescaler returns to 0.
- **Terminal value:** all digits 9 when `up`=1; all digits 0 when `up`=0.
- **Step arithmetic:** per-digit BCD with ripple carry (up) or borrow (down).
  - Up: 9→0 with carry.
  - Down: 0→9 with borrow.
  - Up from all-9s with `wrap`=1 gives all-0s; down from all-0s gives all-9s.
- **`tc`:** registered. It is high for the one cycle in which `count` first shows the terminal value after a step.
  - Loading or clearing to the terminal value does not assert `tc`.
- **Load sanitising:** any `load_val` digit greater than 9 is stored as 9.
- **Priority in a single cycle:** `clear` > `load` > step.
  - A `clear` or `load` coincident with `tick` wins, and that step is lost.
- **Lap hold:**
  - `hold` toggles on each `lap` pulse.
  - When `hold` goes 0→1, `display` captures the current `count`.
  - While `hold`=0, `display` follows `count` registered, i.e. one cycle late.
  - `clear` also forces `hold`=0.
- **Direction change:** `up` may change at any time. It takes effect at the next step, and the terminal value follows the new direction.

## Timing

- **Reset values:** `count`=0, `display`=0, `hold`=0, prescaler=0, `tick`=0, `tc`=0, `state`=IDLE.
  - Reset asserted mid-run returns all of these immediately (asynchronously).
- **First step:** with `en` rising at edge E, `state`=RUN after E. `tick` is high in the cycle after edge E+DIV-1, and `count` updates at edge E+DIV.
- **`clear`/`load` latency:** `count` updates one edge after the pulse. `display` follows one edge later (if `hold`=0).
- **`tc` and `state`:** `tc` and `state`=EXPIRED appear on the same edge as the terminal `count`.
- **No combinational paths:** no input reaches any output combinationally.

## Structure

- **Shared package `timer_pkg`:**
  - `typedef enum logic [1:0] {IDLE, RUN, EXPIRED} timer_state_t`.
  - `localparam logic [3:0] BCD_MAX = 4'd9`.
  - Function `bcd_sat(logic [3:0])` for load sanitising.
- **Sub-module `bcd_digit`:**
  - Ports: `clk`, `rst_n`, `step`, `up`, `cin`, `set`, `set_val`, `zero`; outputs `q`, `cout`.
  - Instantiated DIGITS times in a generate loop, with `cout` chained to the next `cin`.
  - Carry out means q=9 in up mode, and q=0 in down mode.
- **Top level:** prescaler, FSM, `tc` register and lap register stay inline in `bcd_timer`.

## Test plan

All scenarios use DIV=4 and DIGITS=4.

- **Basic up count:** reset, then `en`=1, `up`=1 → `tick` every 4 cycles; `count` goes 0000,0001,…,0009,0010. The first step lands 4 edges after `en` rises.
- **Down count to expiry:** `load` 0003, `up`=0, `wrap`=0, `en`=1 → `count` goes 0002,0001,0000; `tc` is high for 1 cycle at 0000; `state`=EXPIRED; `count` holds 0000 despite `en`. A following `load` returns to IDLE.
- **Wrap:** `load` 9998, `up`=1, `wrap`=1 → `count` goes 9999 with `tc` pulsing, then 0000 with no `tc`; `state` stays RUN.
- **Priority and sanitising:** `load_val`=0xA5F3 → `count`=9593. `clear` together with `load` → 0000. `clear` coincident with `tick` → 0000, and the step is discarded.
- **Lap hold:** run to 0012 and pulse `lap` → `display` holds 0012 while `count` reaches 0015. A second `lap` pulse → `display` tracks `count` one cycle late.
- **Reset mid-run:** drop `rst_n` mid-run while `count`=0047 and `hold`=1 → all outputs go to 0 and IDLE immediately. After release, nothing counts until `en`=1.
